// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock, LSB chunk first, N = WIDTH/CHUNK cycles per result.
// Optional macro CHUNKED_ADDER_SUB_EN adds a Sub input selecting A + ~B + 1.
module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_d;
  logic             accept_c;
  logic             busy_d, done_d;

  logic [WIDTH-1:0] a_q, b_q, psum_q, psum_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             cout_c, cmsb_c;

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d  = BUSY;
          accept_c = 1'b1;
        end
      end
      BUSY: begin
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d  = BUSY;
          accept_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
    done_d = (state == BUSY) && (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Select the current chunk, ripple it, and merge it into the partial sum
  always_comb begin
    logic cr;
    ch_a   = '0;
    ch_b   = '0;
    ch_s   = '0;
    cmsb_c = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      if (idx_q == IW'(c)) begin
        ch_a = a_q[c*CHUNK +: CHUNK];
        ch_b = b_q[c*CHUNK +: CHUNK];
      end
    end
    cr = carry_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb_c = cr;
      ch_s[i] = ch_a[i] ^ ch_b[i] ^ cr;
      cr      = (ch_a[i] & ch_b[i]) | (cr & (ch_a[i] ^ ch_b[i]));
    end
    cout_c = cr;
    psum_d = psum_q;
    for (int unsigned c = 0; c < N; c++) begin
      if (idx_q == IW'(c)) psum_d[c*CHUNK +: CHUNK] = ch_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      psum_q   <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept_c) begin
      a_q     <= A;
`ifdef CHUNKED_ADDER_SUB_EN
      // Subtract is A + ~B + 1, so the inverted operand is what gets latched
      b_q     <= Sub ? ~B : B;
      carry_q <= Sub | Cin;
`else
      b_q     <= B;
      carry_q <= Cin;
`endif
      idx_q   <= '0;
      psum_q  <= '0;
    end else if (state == BUSY) begin
      psum_q  <= psum_d;
      carry_q <= cout_c;
      if (idx_q != LAST) idx_q <= idx_q + IW'(1);
      if (done_d) begin
        Sum      <= psum_d;
        Cout     <= cout_c;
        Overflow <= cmsb_c ^ cout_c;
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (16/4 instance plus an 8/8 instance).
// Exercises the Sub path when CHUNKED_ADDER_SUB_EN is defined.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start, cin;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, ovf;

  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8;
`ifdef CHUNKED_ADDER_SUB_EN
  logic        sub, sub8;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        last_ovf = 1'b0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .Sub(sub),
`endif
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Overflow(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
`ifdef CHUNKED_ADDER_SUB_EN
    .Sub(sub8),
`endif
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Overflow(ovf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {overflow, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] model16(input logic [15:0] oa, input logic [15:0] ob,
                                          input logic oc, input logic os);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] r;
    logic        ov;
    bb = os ? ~ob : ob;
    cc = os ? 1'b1 : oc;
    r  = {1'b0, oa} + {1'b0, bb} + 17'(cc);
    ov = (oa[15] == bb[15]) && (r[15] != oa[15]);
    return {ov, r};
  endfunction

  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                        input logic os, input bit noisy);
    logic [17:0] e;
    int cyc, bcnt;
    e = model16(oa, ob, oc, os);
    start = 1'b1; a = oa; b = ob; cin = oc;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = os;
`endif
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    check("sum_held_in_busy", 64'(sum), 64'(last_sum));
    check("cout_held_in_busy", 64'(cout), 64'(last_cout));
    check("ovf_held_in_busy", 64'(ovf), 64'(last_ovf));
    cyc = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      if (noisy) start = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (!done && busy) bcnt++;
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'd4);
    check("busy_cycles", 64'(bcnt), 64'd4);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("sum", 64'(sum), 64'(e[15:0]));
    check("cout", 64'(cout), 64'(e[16]));
    check("ovf", 64'(ovf), 64'(e[17]));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("sum_held_after_done", 64'(sum), 64'(e[15:0]));
    last_sum = e[15:0]; last_cout = e[16]; last_ovf = e[17];
  endtask

  initial begin
    logic [15:0] qa [7];
    logic [15:0] qb [7];
    logic        qc [7];
    logic [17:0] e;
    logic [8:0]  r8;
    logic        os;
    int          cyc, dcnt;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b0; sub8 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // Directed vectors
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("wrap_sum", 64'(sum), 64'h0000);
    check("wrap_cout", 64'(cout), 64'd1);
    check("wrap_ovf", 64'(ovf), 64'd0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("sovf_sum", 64'(sum), 64'h8000);
    check("sovf_cout", 64'(cout), 64'd0);
    check("sovf_ovf", 64'(ovf), 64'd1);
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0);
    check("cin_sum", 64'(sum), 64'h2346);
    check("cin_cout", 64'(cout), 64'd0);

    // Random operations with start toggling during BUSY
    for (int i = 0; i < 20; i++) begin
      os = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
      os = 1'($urandom);
`endif
      run_op(16'($urandom), 16'($urandom), 1'($urandom), os, 1'b1);
    end

    // Back-to-back with start held high
    for (int i = 0; i < 7; i++) begin
      qa[i] = 16'($urandom); qb[i] = 16'($urandom); qc[i] = 1'($urandom);
    end
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1; a = qa[0]; b = qb[0]; cin = qc[0];
    for (int i = 0; i < 6; i++) begin
      e = model16(qa[i], qb[i], qc[i], 1'b0);
      cyc = 0;
      @(posedge clk); #1;
      cyc++;
      a = qa[i+1]; b = qb[i+1]; cin = qc[i+1];
      while (!done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("b2b_period", 64'(cyc), 64'd5);
      check("b2b_sum", 64'(sum), 64'(e[15:0]));
      check("b2b_cout", 64'(cout), 64'(e[16]));
      check("b2b_ovf", 64'(ovf), 64'(e[17]));
      last_sum = e[15:0]; last_cout = e[16]; last_ovf = e[17];
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset two cycles into BUSY aborts the operation
    start = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    run_op(16'h4321, 16'h0FED, 1'b0, 1'b0, 1'b0);

`ifdef CHUNKED_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    check("sub_sum", 64'(sum), 64'hFFFE);
    check("sub_cout", 64'(cout), 64'd0);
    check("sub_ovf", 64'(ovf), 64'd0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    check("subovf_sum", 64'(sum), 64'h7FFF);
    check("subovf_ovf", 64'(ovf), 64'd1);
`endif

    // Single-chunk instance: latency 1
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      r8 = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
      os = (a8[7] == b8[7]) && (r8[7] != a8[7]);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      check("w8_busy", 64'(busy8), 64'd1);
      cyc = 0;
      while (!done8 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("w8_latency", 64'(cyc), 64'd1);
      check("w8_sum", 64'(sum8), 64'(r8[7:0]));
      check("w8_cout", 64'(cout8), 64'(r8[8]));
      check("w8_ovf", 64'(ovf8), 64'(os));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
